present_enc_sequencer: RTL and testbench

//  Iterative PRESENT-80 encryption controller. Accepts one key/plaintext pair over a valid/ready

---
 rtl/present_pkg.sv | 39 +++
 rtl/present_key_update.sv | 16 +
 rtl/present_enc_sequencer.sv | 101 ++++++++++
 tb/tb_present_enc_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - PRESENT-80 constants, FSM encoding and round-layer helper functions
package present_pkg;

    localparam int ROUNDS_MAX = 31;

    // Nibble x of the S-box is held in bits [4x+3:4x].
    localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            r[6'(4*j) +: 4] = sbox4(s[6'(4*j) +: 4]);
        end
        return r;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] r;
        r     = '0;
        r[63] = s[63];
        for (int i = 0; i < 63; i++) begin
            r[6'((16*i) % 63)] = s[6'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/present_key_update.sv
// rtl/present_key_update.sv - PRESENT-80 key schedule step: rotate, S-box top nibble, XOR round counter
module present_key_update
    import present_pkg::*;
(
    input  logic [79:0] key_i,
    input  logic [4:0]  rc_i,
    output logic [79:0] key_o
);

    logic [79:0] rot;

    // Rotate left by 61 is the same as rotate right by 19.
    assign rot   = {key_i[18:0], key_i[79:19]};
    assign key_o = {sbox4(rot[79:76]), rot[75:20], rot[19:15] ^ rc_i, rot[14:0]};

endmodule

// File: rtl/present_enc_sequencer.sv
// rtl/present_enc_sequencer.sv - iterative PRESENT-80 encryption sequencer, one round per clock
// Optional ROUNDKEY_TAP_EN exposes the per-round key on rk_valid/rk_out.
module present_enc_sequencer
    import present_pkg::*;
#(
    parameter int ROUNDS = 31,
    parameter int CNT_W  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [79:0] key,
    input  logic [63:0] plaintext,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] ciphertext,
    output logic        busy
`ifdef ROUNDKEY_TAP_EN
    ,
    output logic        rk_valid,
    output logic [63:0] rk_out
`endif
);

    localparam int RC_LIMIT = (ROUNDS > ROUNDS_MAX) ? ROUNDS_MAX : ROUNDS;

    state_e             fsm_q;
    logic [63:0]        blk_q;
    logic [79:0]        key_q;
    logic [CNT_W-1:0]   rc_q;
    logic               out_valid_q;
    logic [63:0]        ct_q;

    logic [63:0]        blk_d;
    logic [79:0]        key_d;
    logic [4:0]         rc5;

    assign rc5   = 5'(rc_q);
    assign blk_d = p_layer(sbox_layer(blk_q ^ key_q[79:16]));

    present_key_update u_key_update (
        .key_i (key_q),
        .rc_i  (rc5),
        .key_o (key_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q       <= ST_IDLE;
            blk_q       <= '0;
            key_q       <= '0;
            rc_q        <= CNT_W'(1);
            out_valid_q <= 1'b0;
            ct_q        <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        blk_q <= plaintext;
                        key_q <= key;
                        rc_q  <= CNT_W'(1);
                        fsm_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    blk_q <= blk_d;
                    key_q <= key_d;
                    rc_q  <= rc_q + CNT_W'(1);
                    if (rc_q == CNT_W'(RC_LIMIT)) begin
                        fsm_q <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    ct_q        <= blk_q ^ key_q[79:16];
                    out_valid_q <= 1'b1;
                    fsm_q       <= ST_DONE;
                end
                ST_DONE: begin
                    // Consuming the result never overlaps an accept: IDLE is entered next cycle.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= ST_IDLE;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (fsm_q == ST_IDLE);
    assign busy       = (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);
    assign out_valid  = out_valid_q;
    assign ciphertext = ct_q;

`ifdef ROUNDKEY_TAP_EN
    assign rk_valid = busy;
    assign rk_out   = busy ? key_q[79:16] : 64'd0;
`endif

endmodule

// File: tb/tb_present_enc_sequencer.sv
// tb/tb_present_enc_sequencer.sv - scoreboard bench for present_enc_sequencer with a behavioural PRESENT-80 model
module tb_present_enc_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [79:0] key = '0;
    logic [63:0] plaintext = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] ciphertext;
    logic        busy;
`ifdef ROUNDKEY_TAP_EN
    logic        rk_valid;
    logic [63:0] rk_out;
    logic [63:0] rk_log[$];
`endif

    present_enc_sequencer #(.ROUNDS(31), .CNT_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key        (key),
        .plaintext  (plaintext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
`ifdef ROUNDKEY_TAP_EN
        ,
        .rk_valid   (rk_valid),
        .rk_out     (rk_out)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] ct;
        int          edge_n;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          hold_ready = 1'b0;
    bit          held = 1'b0;
    bit          post = 1'b0;
    logic [63:0] held_ct;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        out_ready = hold_ready ? 1'b0 : ($urandom_range(2) != 0);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Plain PRESENT-80: 31 rounds then whitening with K32.
    function automatic void ref_model(input logic [79:0] k, input logic [63:0] p,
                                      output logic [63:0] ct, output logic [63:0] last_rk);
        int          sb[16];
        logic [63:0] s, t;
        logic [79:0] kk;
        sb = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
        s  = p;
        kk = k;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ kk[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
            t = '0;
            for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
            s  = t;
            kk = (kk << 61) | (kk >> 19);
            kk[79:76] = 4'(sb[kk[79:76]]);
            kk[19:15] = kk[19:15] ^ 5'(r);
        end
        last_rk = kk[79:16];
        ct      = s ^ kk[79:16];
    endfunction

    function automatic logic [63:0] ref_enc(input logic [79:0] k, input logic [63:0] p);
        logic [63:0] c, l;
        ref_model(k, p, c, l);
        return c;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            held = 1'b0;
            post = 1'b0;
        end else begin
            if (post) begin
                check("ready_after_consume", 64'({out_valid, in_ready}), 64'b01);
                post = 1'b0;
            end
            if (busy || out_valid) check("in_ready_blocked", 64'(in_ready), 64'd0);
            if (out_valid && !held) begin
                held    = 1'b1;
                held_ct = ciphertext;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected no output", ciphertext);
                end else begin
                    e = sb_q.pop_front();
                    check("ciphertext", ciphertext, e.ct);
                    check("latency", 64'(cyc - e.edge_n), 64'd32);
                end
            end else if (out_valid) begin
                check("ct_stable", ciphertext, held_ct);
            end
            if (out_valid && out_ready) begin
                held = 1'b0;
                post = 1'b1;
            end
        end
    end

`ifdef ROUNDKEY_TAP_EN
    always @(negedge clock) if (rk_valid) rk_log.push_back(rk_out);
`endif

    task automatic send(input logic [79:0] k, input logic [63:0] p, input logic [63:0] exp,
                        input bit toggle);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clock);
        key       = k;
        plaintext = p;
        in_valid  = 1'b1;
        while (!in_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            in_valid = 1'b0;
            return;
        end
        e.ct     = exp;
        e.edge_n = cyc + 1;
        sb_q.push_back(e);
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        check("busy_after_accept", 64'({busy, in_ready}), 64'b10);
        if (toggle) begin
            repeat (20) begin
                key       = {$urandom, $urandom, 16'($urandom)};
                plaintext = {$urandom, $urandom};
                in_valid  = 1'($urandom_range(1));
                @(negedge clock);
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 400 && sb_q.size() != 0; n++) @(negedge clock);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_ciphertext"}, ciphertext, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [79:0] rk;
        logic [63:0] rp;
        int          n;

        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;

        // Known answers, including back-to-back requests with the consume/accept bubble.
        send(80'd0, 64'd0, 64'h5579C1387B228445, 1'b0);
        drain();
        send({80{1'b1}}, 64'd0, 64'hE72C46C0F5945049, 1'b0);
        send({80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2, 1'b0);
        drain();

        // Consumer stalls for 10 cycles.
        hold_ready = 1'b1;
        send(80'd0, {64{1'b1}}, 64'hA112FFC72F68417B, 1'b0);
        for (n = 0; n < 100 && !out_valid; n++) @(negedge clock);
        repeat (10) begin
            @(negedge clock);
            check("t3_hold_valid", 64'({out_valid, in_ready}), 64'b10);
            check("t3_hold_ct", ciphertext, 64'hA112FFC72F68417B);
        end
        hold_ready = 1'b0;
        drain();

        // Random blocks, some with inputs churning during ROUND.
        for (int i = 0; i < 8; i++) begin
            rk = {$urandom, $urandom, 16'($urandom)};
            rp = {$urandom, $urandom};
            send(rk, rp, ref_enc(rk, rp), i[0]);
        end
        drain();

        // Reset mid-block, then a fresh request.
        send({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 64'd0, 1'b0);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clock);
        check_reset_values("midreset");
        reset = 1'b0;
        repeat (40) @(negedge clock);
        send(80'd0, 64'd0, 64'h5579C1387B228445, 1'b0);
        drain();

`ifdef ROUNDKEY_TAP_EN
        repeat (3) @(negedge clock);
        rk_log.delete();
        send(80'd0, 64'd0, 64'h5579C1387B228445, 1'b0);
        drain();
        begin
            logic [63:0] c, l;
            ref_model(80'd0, 64'd0, c, l);
            check("rk_count", 64'(rk_log.size()), 64'd32);
            if (rk_log.size() == 32) begin
                check("rk_k1", rk_log[0], 64'd0);
                check("rk_k2", rk_log[1], 64'hC000000000000000);
                check("rk_k32", rk_log[31], l);
            end
        end
`endif

        repeat (5) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
